// File: rtl/nibble_sub_seq.sv
// Multi-cycle subtract sequencer: a - b - bin computed one nibble per clock
// through a single shared 4-bit subtract slice, borrow chained via a register.

// 4-bit ripple-borrow subtract slice.
module sub4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       bin_i,
  output logic [3:0] d_o,
  output logic       bout_o
);

  logic [4:0] br;

  // Per-bit difference with the borrow rippled from bit 0 upward.
  always_comb begin
    br    = '0;
    d_o   = '0;
    br[0] = bin_i;
    for (int unsigned i = 0; i < 4; i++) begin
      d_o[i]  = a_i[i] ^ b_i[i] ^ br[i];
      br[i+1] = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & br[i]);
    end
    bout_o = br[4];
  end

endmodule

module nibble_sub_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             overflow
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             brw_q, brw_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic [3:0]       nib_a, nib_b, nib_d;
  logic             nib_bout;

  assign nib_a = a_q[{idx_q, 2'b00} +: 4];
  assign nib_b = b_q[{idx_q, 2'b00} +: 4];

  sub4 u_sub4 (
    .a_i    (nib_a),
    .b_i    (nib_b),
    .bin_i  (brw_q),
    .d_o    (nib_d),
    .bout_o (nib_bout)
  );

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      brw_q    <= 1'b0;
      idx_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      brw_q    <= brw_d;
      idx_q    <= idx_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state: capture in IDLE, one nibble per RUN cycle, hold in DONE.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    brw_d    = brw_q;
    idx_d    = idx_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        diff_d[{idx_q, 2'b00} +: 4] = nib_d;
        brw_d = nib_bout;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          // Flags use the fully assembled result including this last nibble.
          borrow_d = nib_bout;
          zero_d   = (diff_d == '0);
          ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                     (diff_d[WIDTH-1] != a_q[WIDTH-1]);
          idx_d    = '0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_nibble_sub_seq.sv
// Bench for nibble_sub_seq: WIDTH=8 and WIDTH=16 instances, scoreboard of
// expected results from a full-width arithmetic model.
module tb_nibble_sub_seq;

  typedef struct packed {
    logic [15:0] diff;
    logic        borrow;
    logic        zero;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel16;
  logic        drv_valid, drv_oready, drv_bin;
  logic [15:0] drv_a, drv_b;

  logic        ir8, ov8, br8, z8, of8;
  logic [7:0]  d8;
  logic        ir16, ov16, br16, z16, of16;
  logic [15:0] d16;

  logic        obs_ready, obs_valid, obs_borrow, obs_zero, obs_ovf;
  logic [15:0] obs_diff;

  int n_checks = 0;
  int n_err    = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  nibble_sub_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(drv_valid & ~sel16), .in_ready(ir8),
    .a(drv_a[7:0]), .b(drv_b[7:0]), .bin(drv_bin),
    .out_valid(ov8), .out_ready(drv_oready & ~sel16),
    .diff(d8), .borrow(br8), .zero(z8), .overflow(of8)
  );

  nibble_sub_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(drv_valid & sel16), .in_ready(ir16),
    .a(drv_a), .b(drv_b), .bin(drv_bin),
    .out_valid(ov16), .out_ready(drv_oready & sel16),
    .diff(d16), .borrow(br16), .zero(z16), .overflow(of16)
  );

  assign obs_ready  = sel16 ? ir16 : ir8;
  assign obs_valid  = sel16 ? ov16 : ov8;
  assign obs_diff   = sel16 ? d16  : {8'h00, d8};
  assign obs_borrow = sel16 ? br16 : br8;
  assign obs_zero   = sel16 ? z16  : z8;
  assign obs_ovf    = sel16 ? of16 : of8;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic bin);
    logic [16:0] full;
    logic [15:0] m;
    exp_t e;
    m        = (w == 8) ? 16'h00FF : 16'hFFFF;
    full     = {1'b0, a & m} - {1'b0, b & m} - {16'b0, bin};
    e.diff   = full[15:0] & m;
    e.borrow = full[16];
    e.zero   = (e.diff == 16'h0);
    e.ovf    = (a[w-1] != b[w-1]) && (e.diff[w-1] != a[w-1]);
    return e;
  endfunction

  // One operation: drive, wait for result (bounded), compare, optional
  // back-pressure with fresh operands on in_valid, then handshake.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        input int hold);
    exp_t e;
    int   lat;
    int   w;
    w = sel16 ? 16 : 8;
    e = '0;
    @(negedge clk);
    check("idle_ready", obs_ready, 1);
    drv_a = a; drv_b = b; drv_bin = bin; drv_valid = 1'b1;
    sb.push_back(model(w, a, b, bin));
    @(posedge clk);
    lat = 0;
    forever begin
      @(negedge clk);
      drv_valid = 1'b0;
      if (obs_valid || lat >= 20) break;
      check("busy_ready", obs_ready, 0);
      @(posedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(w / 4));
    if (sb.size() == 0) check("sb_nonempty", 0, 1);
    else e = sb.pop_front();
    check("diff", obs_diff, e.diff);
    check("borrow", obs_borrow, e.borrow);
    check("zero", obs_zero, e.zero);
    check("ovf", obs_ovf, e.ovf);
    for (int i = 0; i < hold; i++) begin
      drv_valid = 1'b1; drv_a = ~a; drv_b = a; drv_bin = ~bin;
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", obs_valid, 1);
      check("hold_ready", obs_ready, 0);
      check("hold_diff", obs_diff, e.diff);
      check("hold_borrow", obs_borrow, e.borrow);
    end
    drv_valid  = 1'b0;
    drv_oready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drv_oready = 1'b0;
    check("post_valid", obs_valid, 0);
    check("post_ready", obs_ready, 1);
    check("idle_diff", obs_diff, e.diff);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sel16 = 1'b0;
    drv_valid = 1'b0; drv_oready = 1'b0; drv_bin = 1'b0;
    drv_a = '0; drv_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready8", ir8, 0);
    check("rst_ready16", ir16, 0);
    check("rst_valid", ov8, 0);
    check("rst_diff", d8, 0);
    check("rst_flags", {br8, z8, of8}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_ready", ir8, 1);

    run_op(16'h5A, 16'h3C, 1'b0, 0);
    run_op(16'h10, 16'h20, 1'b0, 0);
    run_op(16'h80, 16'h01, 1'b0, 0);
    run_op(16'h33, 16'h33, 1'b0, 0);
    run_op(16'h00, 16'h00, 1'b1, 0);
    run_op(16'hC3, 16'h42, 1'b1, 5);
    run_op(16'h7F, 16'hFF, 1'b0, 0);

    // Reset during the second RUN cycle discards the operation.
    @(negedge clk);
    drv_a = 16'h5A; drv_b = 16'h3C; drv_bin = 1'b0; drv_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drv_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("midrst_ready", ir8, 0);
    @(posedge clk);
    @(negedge clk);
    check("midrst_valid", ov8, 0);
    check("midrst_diff", d8, 0);
    check("midrst_flags", {br8, z8, of8}, 0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_rel_ready", ir8, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_no_valid", ov8, 0);
    end

    for (int i = 0; i < 6; i++)
      run_op(16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 0);

    sel16 = 1'b1;
    run_op(16'h1000, 16'h0001, 1'b0, 0);
    run_op(16'h0000, 16'h0001, 1'b0, 0);
    run_op(16'h8000, 16'h0001, 1'b0, 2);
    for (int i = 0; i < 4; i++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
